// File: rtl/sid_bus_writer_if.sv
// Request handshake and SID bus signals of sid_bus_writer.
// slave = the bus writer itself, master = the request side that drives it.
interface sid_bus_writer_if;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_addr;
  logic [7:0] req_data;
  logic       req_rw;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       sid_clk;
  logic       sid_res_n;
  logic       sid_cs_n;
  logic       sid_rw;
  logic [4:0] sid_addr;
  logic [7:0] sid_data_o;
  logic       sid_data_oe;
  logic [7:0] sid_data_i;
  logic       busy;

  modport slave (
    input  req_valid, req_addr, req_data, req_rw, sid_data_i,
    output req_ready, rd_data, rd_valid, sid_clk, sid_res_n, sid_cs_n,
           sid_rw, sid_addr, sid_data_o, sid_data_oe, busy
  );

  modport master (
    output req_valid, req_addr, req_data, req_rw, sid_data_i,
    input  req_ready, rd_data, rd_valid, sid_clk, sid_res_n, sid_cs_n,
           sid_rw, sid_addr, sid_data_o, sid_data_oe, busy
  );
endinterface

// File: rtl/sid_bus_writer.sv
// SID bus writer: generates phi2, holds the SID in reset, then issues queued register
// accesses as phi2-aligned bus cycles. Define SID_READ_EN to enable read cycles.
module sid_bus_writer #(
  parameter int SYS_CLK      = 20000000,
  parameter int CLK_OUT      = 1000000,
  parameter int FIFO_DEPTH   = 4,
  parameter int RESET_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  sid_bus_writer_if.slave bus
);
  localparam int DIV = SYS_CLK / CLK_OUT;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(DIV / 2);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 1);
  localparam logic [RCW-1:0] RISE_DONE = RCW'(RESET_CYCLES);

  if ((DIV % 2) != 0 || DIV < 4) begin : g_bad_div
    $error("sid_bus_writer: SYS_CLK/CLK_OUT must be even and >= 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sid_bus_writer: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (RESET_CYCLES < 10) begin : g_bad_reset
    $error("sid_bus_writer: RESET_CYCLES must be >= 10");
  end

  typedef enum logic [2:0] {ST_RESET, ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_e;

  typedef struct packed {
    logic       rw;
    logic [4:0] addr;
    logic [7:0] data;
  } req_t;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RCW-1:0] rise_q, rise_d;
  logic           sid_clk_q, sid_clk_d;
  logic           res_n_q, res_n_d;
  logic           cs_n_q, cs_n_d;
  logic           rw_q, rw_d;
  logic [4:0]     addr_q, addr_d;
  logic [7:0]     data_o_q, data_o_d;
  logic           oe_q, oe_d;
  logic [7:0]     rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           req_ready_q, req_ready_d;
  logic           busy_q, busy_d;
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic           push, pop, empty_q, empty_d, full_d;
  req_t           head;
  req_t           mem [FIFO_DEPTH];

  // Every "at cnt==N" event fires on the edge where cnt becomes N, so bus
  // outputs change together with the phi2 edge they belong to.
  always_comb begin
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    sid_clk_d = (cnt_d >= CNT_HALF);
  end

  assign push    = bus.req_valid && req_ready_q;
  assign empty_q = (wr_ptr_q == rd_ptr_q);
  assign head    = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    empty_d     = (wr_ptr_d == rd_ptr_d);
    full_d      = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    req_ready_d = !full_d;
    busy_d      = !empty_d || (state_d != ST_IDLE);
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = state_q;
    rise_d     = rise_q;
    res_n_d    = res_n_q;
    cs_n_d     = cs_n_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_o_d   = data_o_q;
    oe_d       = oe_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        if (cnt_q == CNT_HALF - 1'b1 && rise_q != RISE_DONE) rise_d = rise_q + 1'b1;
        if (cnt_d == '0 && rise_q == RISE_DONE) begin
          res_n_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cnt_d == '0 && !empty_q) begin
          pop     = 1'b1;
          addr_d  = head.addr;
          state_d = ST_SETUP;
`ifdef SID_READ_EN
          rw_d = head.rw;
          oe_d = !head.rw;
          if (!head.rw) data_o_d = head.data;
`else
          rw_d     = 1'b0;
          oe_d     = 1'b1;
          data_o_d = head.data;
`endif
        end
      end
      ST_SETUP: begin
        if (cnt_d == CNT_HALF) begin
          cs_n_d  = 1'b0;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
`ifdef SID_READ_EN
        // The SID drives read data until phi2 falls; take it in the last clk of phi2 high.
        if (cnt_q == CNT_LAST && rw_q) begin
          rd_data_d  = bus.sid_data_i;
          rd_valid_d = 1'b1;
        end
`endif
        if (cnt_d == '0) begin
          cs_n_d  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        oe_d    = 1'b0;
        rw_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

`ifndef SID_READ_EN
  logic unused_read_path;
  assign unused_read_path = ^{bus.sid_data_i, head.rw};
`endif

  // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= req_t'{rw: bus.req_rw, addr: bus.req_addr, data: bus.req_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      rise_q      <= '0;
      sid_clk_q   <= 1'b0;
      res_n_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      rw_q        <= 1'b1;
      addr_q      <= '0;
      data_o_q    <= '0;
      oe_q        <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rise_q      <= rise_d;
      sid_clk_q   <= sid_clk_d;
      res_n_q     <= res_n_d;
      cs_n_q      <= cs_n_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_o_q    <= data_o_d;
      oe_q        <= oe_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.sid_clk     = sid_clk_q;
  assign bus.sid_res_n   = res_n_q;
  assign bus.sid_cs_n    = cs_n_q;
  assign bus.sid_rw      = rw_q;
  assign bus.sid_addr    = addr_q;
  assign bus.sid_data_o  = data_o_q;
  assign bus.sid_data_oe = oe_q;
  assign bus.busy        = busy_q;
endmodule
